// File: rtl/mcpc_pkg.sv
// Shared constants for the multi-channel prescaled event counter.
// Default widths and the encoding of the per-channel overflow mode.
package mcpc_pkg;

  localparam int CNT_W_DEF = 64;
  localparam int PRE_W_DEF = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : mcpc_pkg

// File: rtl/counter_channel.sv
// One channel of the prescaled event counter: prescaler, main counter,
// overflow mode, sticky overflow flag and advance pulse.
module counter_channel
  import mcpc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ev,
  input  logic             cfg_we,
  input  logic             clr,
  input  logic [PRE_W-1:0] cfg_div,
  input  logic             cfg_sat,
  output logic [CNT_W-1:0] cnt_r,
  output logic             ovf_r,
  output logic             inc_r
);

  logic [PRE_W-1:0] pre_r;
  logic [PRE_W-1:0] div_r;
  logic             sat_r;

  logic             hit_s;
  logic             at_max_s;
  logic             adv_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [PRE_W-1:0] pre_evt_s;
  logic [PRE_W-1:0] pre_nxt_s;
  logic             ovf_nxt_s;

  // Next-state evaluation: clear wins over an event, config only retargets the prescaler.
  always_comb begin
    hit_s     = (pre_r == div_r);
    at_max_s  = (cnt_r == {CNT_W{1'b1}});
    adv_s     = 1'b0;
    cnt_nxt_s = cnt_r;
    pre_evt_s = pre_r;
    ovf_nxt_s = ovf_r;
    if (clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      pre_evt_s = {PRE_W{1'b0}};
      ovf_nxt_s = 1'b0;
    end else if (ev && hit_s) begin
      adv_s     = 1'b1;
      pre_evt_s = {PRE_W{1'b0}};
      if (at_max_s) begin
        ovf_nxt_s = 1'b1;
        if (sat_r == MODE_SAT) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else if (ev) begin
      // After a divisor decrease pre may sit above div; it simply wraps round.
      pre_evt_s = pre_r + PRE_W'(1);
    end else begin
      pre_evt_s = pre_r;
    end

    if (cfg_we) begin
      pre_nxt_s = {PRE_W{1'b0}};
    end else begin
      pre_nxt_s = pre_evt_s;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r <= {CNT_W{1'b0}};
      pre_r <= {PRE_W{1'b0}};
      div_r <= {PRE_W{1'b0}};
      sat_r <= MODE_WRAP;
      ovf_r <= 1'b0;
      inc_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      pre_r <= pre_nxt_s;
      ovf_r <= ovf_nxt_s;
      inc_r <= adv_s;
      if (cfg_we) begin
        div_r <= cfg_div;
        sat_r <= cfg_sat;
      end else begin
        div_r <= div_r;
        sat_r <= sat_r;
      end
    end
  end

endmodule : counter_channel

// File: rtl/multi_channel_prescaled_counter.sv
// N-channel prescaled event counter: decodes the event/config/clear channel
// selects into per-channel strobes and muxes one channel count for readback.
module multi_channel_prescaled_counter
  import mcpc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [SEL_W-1:0] Slt,
  input  logic             CfgWe,
  input  logic [SEL_W-1:0] CfgCh,
  input  logic [PRE_W-1:0] CfgDiv,
  input  logic             CfgSat,
  input  logic             Clr,
  input  logic [SEL_W-1:0] ClrCh,
  input  logic [SEL_W-1:0] RdCh,
  output logic [CNT_W-1:0] RdCount,
  output logic [N_CH-1:0]  Ovf,
  output logic [N_CH-1:0]  Inc
);

  logic [N_CH-1:0]  ev_s;
  logic [N_CH-1:0]  cfg_s;
  logic [N_CH-1:0]  clr_s;
  logic [N_CH-1:0]  rd_sel_s;
  logic [CNT_W-1:0] cnt_s [N_CH];
  logic [CNT_W-1:0] rd_count_s;

  // Out-of-range selects never match any channel index, so they drop out here.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ev_s[c]     = En    & (Slt   == SEL_W'(c));
    assign cfg_s[c]    = CfgWe & (CfgCh == SEL_W'(c));
    assign clr_s[c]    = Clr   & (ClrCh == SEL_W'(c));
    assign rd_sel_s[c] = (RdCh == SEL_W'(c));

    counter_channel #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_channel (
      .Clk     (Clk),
      .Reset   (Reset),
      .ev      (ev_s[c]),
      .cfg_we  (cfg_s[c]),
      .clr     (clr_s[c]),
      .cfg_div (CfgDiv),
      .cfg_sat (CfgSat),
      .cnt_r   (cnt_s[c]),
      .ovf_r   (Ovf[c]),
      .inc_r   (Inc[c])
    );
  end

  // Read mux as an AND-OR tree; an unmatched RdCh yields zero.
  always_comb begin
    rd_count_s = {CNT_W{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      rd_count_s = rd_count_s | (rd_sel_s[c] ? cnt_s[c] : {CNT_W{1'b0}});
    end
  end

  assign RdCount = rd_count_s;

endmodule : multi_channel_prescaled_counter

// File: tb/tb_multi_channel_prescaled_counter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against an arithmetic per-channel reference model.
module tb_multi_channel_prescaled_counter;

  localparam int N  = 5;
  localparam int CW = 4;
  localparam int PW = 4;
  localparam int SW = 3;
  localparam int CMOD = 1 << CW;
  localparam int PMOD = 1 << PW;

  logic          Clk;
  logic          Reset;
  logic          En;
  logic [SW-1:0] Slt;
  logic          CfgWe;
  logic [SW-1:0] CfgCh;
  logic [PW-1:0] CfgDiv;
  logic          CfgSat;
  logic          Clr;
  logic [SW-1:0] ClrCh;
  logic [SW-1:0] RdCh;
  logic [CW-1:0] RdCount;
  logic [N-1:0]  Ovf;
  logic [N-1:0]  Inc;

  int checks = 0;
  int errors = 0;

  int m_cnt [N];
  int m_pre [N];
  int m_div [N];
  bit m_sat [N];
  bit m_ovf [N];
  bit m_inc [N];

  multi_channel_prescaled_counter #(
    .N_CH  (N),
    .CNT_W (CW),
    .PRE_W (PW)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .En      (En),
    .Slt     (Slt),
    .CfgWe   (CfgWe),
    .CfgCh   (CfgCh),
    .CfgDiv  (CfgDiv),
    .CfgSat  (CfgSat),
    .Clr     (Clr),
    .ClrCh   (ClrCh),
    .RdCh    (RdCh),
    .RdCount (RdCount),
    .Ovf     (Ovf),
    .Inc     (Inc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one event per cycle, clear beats event, config resets pre.
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit ev, cf, cl;
      ev = En && (int'(Slt) == c);
      cf = CfgWe && (int'(CfgCh) == c);
      cl = Clr && (int'(ClrCh) == c);
      m_inc[c] = 1'b0;
      if (Reset) begin
        m_cnt[c] = 0; m_pre[c] = 0; m_div[c] = 0; m_sat[c] = 0; m_ovf[c] = 0;
      end else begin
        if (cl) begin
          m_cnt[c] = 0; m_pre[c] = 0; m_ovf[c] = 0;
        end else if (ev) begin
          if (m_pre[c] == m_div[c]) begin
            m_pre[c] = 0;
            m_inc[c] = 1'b1;
            if (m_cnt[c] == CMOD - 1) begin
              m_ovf[c] = 1'b1;
              m_cnt[c] = m_sat[c] ? CMOD - 1 : 0;
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end else begin
            m_pre[c] = (m_pre[c] + 1) % PMOD;
          end
        end
        if (cf) begin
          m_div[c] = int'(CfgDiv);
          m_sat[c] = CfgSat;
          m_pre[c] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eo, ei;
    for (int c = 0; c < N; c++) begin
      eo[c] = m_ovf[c];
      ei[c] = m_inc[c];
    end
    check_value("ovf", 64'(Ovf), 64'(eo));
    check_value("inc", 64'(Inc), 64'(ei));
    for (int c = 0; c < N; c++) begin
      RdCh = SW'(c);
      #1;
      check_value($sformatf("cnt%0d", c), 64'(RdCount), 64'(m_cnt[c]));
    end
    RdCh = SW'(6);
    #1;
    check_value("rd_oor", 64'(RdCount), 64'd0);
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    Reset = 1'b0; En = 1'b0; Slt = '0; CfgWe = 1'b0; CfgCh = '0;
    CfgDiv = '0; CfgSat = 1'b0; Clr = 1'b0; ClrCh = '0;
  endtask

  task automatic expect_count(input int c, input int exp);
    RdCh = SW'(c);
    #1;
    check_value($sformatf("dir_cnt%0d", c), 64'(RdCount), 64'(exp));
  endtask

  task automatic events(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      idle(); En = 1'b1; Slt = SW'(c);
      step();
    end
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_pre[c] = 0; m_div[c] = 0; m_sat[c] = 0; m_ovf[c] = 0; m_inc[c] = 0;
    end
    RdCh = '0;
    idle(); Reset = 1'b1;
    step();
    check_value("rst_ovf", 64'(Ovf), 64'd0);
    check_value("rst_inc", 64'(Inc), 64'd0);

    // Ten events to ch0 with div=0.
    for (int i = 0; i < 10; i++) begin
      idle(); En = 1'b1; Slt = 3'd0;
      step();
      check_value("t1_inc0", 64'(Inc[0]), 64'd1);
    end
    idle();
    expect_count(0, 10);
    expect_count(1, 0);

    // ch1 divide-by-4.
    idle(); CfgWe = 1'b1; CfgCh = 3'd1; CfgDiv = 4'd3;
    step();
    for (int i = 1; i <= 12; i++) begin
      idle(); En = 1'b1; Slt = 3'd1;
      step();
      check_value("t2_inc1", 64'(Inc[1]), (i % 4 == 0) ? 64'd1 : 64'd0);
    end
    idle();
    expect_count(1, 3);

    // ch2 wrap, then saturate.
    idle(); CfgWe = 1'b1; CfgCh = 3'd2; CfgDiv = 4'd0; CfgSat = 1'b0;
    step();
    events(2, 17);
    idle();
    expect_count(2, 1);
    check_value("t3_ovf2_wrap", 64'(Ovf[2]), 64'd1);
    idle(); Clr = 1'b1; ClrCh = 3'd2; CfgWe = 1'b1; CfgCh = 3'd2; CfgSat = 1'b1;
    step();
    check_value("t3_ovf2_clr", 64'(Ovf[2]), 64'd0);
    for (int i = 0; i < 17; i++) begin
      idle(); En = 1'b1; Slt = 3'd2;
      step();
      check_value("t3_inc2_sat", 64'(Inc[2]), 64'd1);
    end
    idle();
    expect_count(2, 15);
    check_value("t3_ovf2_sat", 64'(Ovf[2]), 64'd1);

    // Clear coincident with the 4th ch1 event.
    idle(); Clr = 1'b1; ClrCh = 3'd1;
    step();
    events(1, 3);
    idle(); En = 1'b1; Slt = 3'd1; Clr = 1'b1; ClrCh = 3'd1;
    step();
    check_value("t4_inc1", 64'(Inc[1]), 64'd0);
    check_value("t4_ovf1", 64'(Ovf[1]), 64'd0);
    idle();
    expect_count(1, 0);
    events(1, 3);
    check_value("t4_noinc", 64'(Inc[1]), 64'd0);
    events(1, 1);
    check_value("t4_inc_after", 64'(Inc[1]), 64'd1);
    idle();
    expect_count(1, 1);

    // Config write on ch0 coincident with an advancing event.
    idle(); En = 1'b1; Slt = 3'd0; CfgWe = 1'b1; CfgCh = 3'd0; CfgDiv = 4'd1;
    step();
    idle();
    expect_count(0, 11);
    events(0, 2);
    idle();
    expect_count(0, 12);

    // Mid-stream reset after ch3 reaches 5 with div=2.
    idle(); CfgWe = 1'b1; CfgCh = 3'd3; CfgDiv = 4'd2;
    step();
    events(3, 15);
    idle();
    expect_count(3, 5);
    idle(); Reset = 1'b1; En = 1'b1; Slt = 3'd3; Clr = 1'b1; ClrCh = 3'd1;
    step();
    check_value("t6_ovf", 64'(Ovf), 64'd0);
    check_value("t6_inc", 64'(Inc), 64'd0);
    events(3, 1);
    idle();
    expect_count(3, 1);

    // Random traffic, including out-of-range selects and rare resets.
    for (int i = 0; i < 3000; i++) begin
      idle();
      Reset  = ($urandom_range(0, 299) == 0);
      En     = ($urandom_range(0, 3) != 0);
      Slt    = SW'($urandom_range(0, 7));
      CfgWe  = ($urandom_range(0, 15) == 0);
      CfgCh  = SW'($urandom_range(0, 7));
      CfgDiv = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 15)) : PW'($urandom_range(0, 2));
      CfgSat = 1'($urandom_range(0, 1));
      Clr    = ($urandom_range(0, 39) == 0);
      ClrCh  = SW'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multi_channel_prescaled_counter

// File: doc/multi_channel_prescaled_counter.md
Name: multi_channel_prescaled_counter

Overview:
Parametrised N-channel event counter with a per-channel programmable prescaler, per-channel wrap/saturate mode, sticky overflow flags and per-channel clear. Each enabled cycle delivers one event to the channel addressed by Slt. That channel's prescaler decides whether its main counter advances. Sits beside the CPU bus as a statistics/performance counter block; counts are read through a read-channel mux.

Parameters:
N_CH, 4, number of channels (>=1)
CNT_W, 64, main counter width per channel
PRE_W, 4, prescaler/divisor width per channel
SEL_W, $clog2(N_CH) (min 1), width of channel index ports (derived)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
En  in  1  event strobe for channel Slt this cycle
Slt  in  SEL_W  channel receiving the event
CfgWe  in  1  config write strobe
CfgCh  in  SEL_W  channel being configured
CfgDiv  in  PRE_W  divisor d: counter advances once per d+1 events
CfgSat  in  1  1 = saturate at max, 0 = wrap
Clr  in  1  clear strobe
ClrCh  in  SEL_W  channel to clear
RdCh  in  SEL_W  channel to read
RdCount  out  CNT_W  count of channel RdCh (combinational mux of registers)
Ovf  out  N_CH  sticky overflow flag per channel
Inc  out  N_CH  registered 1-cycle pulse: channel counter advanced on the previous edge

Behaviour:
- Reset, synchronous, active-high; clock Clk. On Reset at posedge: all counts=0, prescalers=0, divisors=0, sat modes=0 (wrap), Ovf=0, Inc=0. Reset overrides every other input, including mid-operation.
- Per-channel state: cnt[CNT_W], pre[PRE_W], div[PRE_W], sat[1], ovf[1].
- Event: En=1 and Slt==c (Slt>=N_CH: event ignored).
  - If pre==div: pre<=0, and the counter advances. Otherwise pre<=pre+1 and cnt is unchanged.
  - div=0 means every event advances. div=3 means every 4th event advances.
- Counter advance:
  - cnt<max: cnt<=cnt+1.
  - cnt==max, wrap mode: cnt<=0, ovf<=1.
  - cnt==max, sat mode: cnt holds max, ovf<=1.
  - Inc[c]<=1 for exactly one cycle in all three cases. Inc[c]=0 on all non-advancing cycles.
- Config write (CfgWe, CfgCh==c): div<=CfgDiv, sat<=CfgSat, pre<=0.
  - An event to c in the same cycle is evaluated with the old div/pre, so cnt may advance. pre still ends at 0.
  - cnt and ovf are unaffected.
- Clear (Clr, ClrCh==c): cnt<=0, pre<=0, ovf<=0, Inc[c]<=0.
  - Clear beats a coincident event on c (no advance, no Inc).
  - Clear plus CfgWe on the same channel: both apply (counters zeroed, new div/sat loaded).
  - Out-of-range ClrCh/CfgCh are ignored.
- Read: RdCount=cnt[RdCh], zero latency; it reflects register state after the last edge. Out-of-range RdCh returns 0.
- Only one event per cycle; channels not addressed hold their state.
- Arithmetic: unsigned, modulo 2^CNT_W in wrap mode. pre never exceeds div except transiently after a divisor decrease. In that case pre==div is false: pre keeps incrementing, wraps modulo 2^PRE_W, and then matches div. No special handling.

Decomposition:
- Package mcpc_pkg: default CNT_W/PRE_W constants and the localparam for mode encoding (MODE_WRAP=0, MODE_SAT=1).
- Sub-module counter_channel holds one channel's cnt/pre/div/sat/ovf/Inc logic. Its inputs are decoded strobes ev, cfg_we, clr and the config data. It is instantiated N_CH times via generate.
- The top level holds only the one-hot decode of Slt/CfgCh/ClrCh and the RdCh read mux.

Test Plan:
- Reset, then En=1, Slt=0 for 10 cycles with div=0 -> RdCh=0 gives RdCount=10; Inc[0] high 10 cycles; other channels 0.
- CfgWe ch1 div=3, then 12 events to ch1 -> RdCount(ch1)=3; Inc[1] pulses on events 4, 8, 12 only.
- CNT_W=4 build, ch2 wrap, 17 events -> cnt=1, Ovf[2]=1. Repeat with CfgSat=1 -> cnt=15, Ovf[2]=1, Inc still pulses each event.
- Clr ch1 coincident with the 4th event (div=3) -> cnt=0, pre=0, Ovf[1]=0, Inc[1]=0 next cycle.
- CfgWe ch0 div=1 coincident with an event when pre==div (old div=0) -> cnt advances by 1, pre=0; the next 2 events give exactly +1.
- Assert Reset mid-stream after ch3 has 5 counts and div=2 -> next cycle all counts, Ovf, Inc, divisors are 0; the first following event to ch3 gives cnt=1.
